timer_dev: RTL and testbench

- Memory-mapped countdown timer. It is the responder on the CPU's M-stage load/store port; the CPU is the initiator, driving address, write enable and write data.
- It sits beside dm behind the address decode, is read combinationally in the same cycle as the CPU's dm access, and raises an interrupt request to the CPU.

---
 rtl/timer_dev_pkg.sv | 34 +++
 rtl/timer_dev_prescaler.sv | 33 +++
 rtl/timer_dev.sv | 171 +++++++++++++++++
 tb/tb_timer_dev.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_dev_pkg.sv
// rtl/timer_dev_pkg.sv - shared register map, CTRL fields, modes and FSM encodings for timer_dev
package timer_defs;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        CNT  = ST_CNT,
        INT  = ST_INT
    } state_e;

    // Modes 2 and 3 behave as one-shot.
    function automatic logic [1:0] mode_eff(input logic [1:0] mode);
        return (mode == MODE_RELOAD) ? MODE_RELOAD : MODE_ONESHOT;
    endfunction

endpackage

// File: rtl/timer_dev_prescaler.sv
// rtl/timer_dev_prescaler.sv - decrement tick generator, one tick every prescale+1 enabled cycles
module timer_prescaler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [15:0] prescale,
    output logic        tick
);

    logic [15:0] div_q, div_d;

    // >= rather than == so a PRESCALE lowered mid-count cannot strand the divider.
    assign tick = enable && (div_q >= prescale);

    always_comb begin
        div_d = div_q;
        if (clear) begin
            div_d = '0;
        end else if (enable) begin
            div_d = tick ? 16'd0 : div_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer with level irq; TIMER_PRESCALE_EN adds a PRESCALE register at offset 3
module timer_dev
    import timer_defs::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int          COUNT_W   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        irq
);

    logic [3:0]         ctrl_q, ctrl_d;
    logic [COUNT_W-1:0] preset_q, preset_d;
    logic [COUNT_W-1:0] count_q, count_d;
    state_e             state_q, state_d;
    logic               irq_pend_q, irq_pend_d;
    logic               irq_q, irq_d;

    logic [1:0]  offset;
    logic        wr_ctrl, wr_preset;
    logic        tick;
    logic [1:0]  mode;
    logic        unused_addr_bits;

    assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset    = addr[3:2];
    assign wr_ctrl   = sel && we && (offset == OFF_CTRL);
    assign wr_preset = sel && we && (offset == OFF_PRESET);
    assign mode      = mode_eff(ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO]);
    assign unused_addr_bits = ^addr[1:0];
    assign irq       = irq_q;

`ifdef TIMER_PRESCALE_EN
    logic [15:0] prescale_q, prescale_d;
    logic        wr_prescale;

    assign wr_prescale = sel && we && (offset == OFF_RSVD);

    always_comb begin
        prescale_d = prescale_q;
        if (wr_prescale) begin
            prescale_d = wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_d;
        end
    end

    timer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_q == LOAD),
        .enable   (state_q == CNT),
        .prescale (prescale_q),
        .tick     (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        state_d    = state_q;
        irq_pend_d = irq_pend_q;

        case (state_q)
            IDLE: begin
                if (ctrl_q[CTRL_EN]) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (count_q <= COUNT_W'(1)) begin
                        count_d = '0;
                        state_d = INT;
                    end else begin
                        count_d = count_q - COUNT_W'(1);
                    end
                end
            end
            INT: begin
                if (mode == MODE_RELOAD) begin
                    state_d = LOAD;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Ordering encodes priority: a CTRL write beats the FSM's EN clear,
        // and an INT set beats both the reload auto-clear and the write clear.
        if (irq_pend_q && (mode == MODE_RELOAD)) begin
            irq_pend_d = 1'b0;
        end
        if (wr_ctrl) begin
            ctrl_d     = wdata[3:0];
            irq_pend_d = 1'b0;
        end
        if (state_q == INT) begin
            irq_pend_d = 1'b1;
        end
        if (wr_preset) begin
            preset_d = wdata[COUNT_W-1:0];
        end

        irq_d = irq_pend_d & ctrl_d[CTRL_IM];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            irq_pend_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            state_q    <= state_d;
            irq_pend_q <= irq_pend_d;
            irq_q      <= irq_d;
        end
    end

    logic [31:0] count_ext, preset_ext, rd_val;

    always_comb begin
        count_ext  = '0;
        preset_ext = '0;
        count_ext[COUNT_W-1:0]  = count_q;
        preset_ext[COUNT_W-1:0] = preset_q;
        rd_val = '0;
        case (offset)
            OFF_CTRL:   rd_val = {28'd0, ctrl_q};
            OFF_PRESET: rd_val = preset_ext;
            OFF_COUNT:  rd_val = count_ext;
`ifdef TIMER_PRESCALE_EN
            OFF_RSVD:   rd_val = {16'd0, prescale_q};
`else
            OFF_RSVD:   rd_val = {31'd0, 1'b0 & unused_addr_bits};
`endif
            default:    rd_val = '0;
        endcase
        rdata = sel ? rd_val : 32'd0;
    end

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - directed self-checking bench for timer_dev
module tb_timer_dev;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        sel;
    logic        irq;

    int total = 0;
    int bad   = 0;

    timer_dev #(.BASE_ADDR(BASE), .COUNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .sel   (sel),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        addr  = BASE + {28'd0, off, 2'b00};
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] off, input logic [31:0] expv);
        addr = BASE + {28'd0, off, 2'b00};
        #1;
        check(tag, rdata, expv);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        we    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int n;
        addr  = 32'd0;
        we    = 1'b0;
        wdata = 32'd0;
        reset = 1'b1;
        tick_n(2);
        reset = 1'b0;

        // Reset state and decode
        chk_reg("rst_ctrl", 2'd0, 32'd0);
        chk_reg("rst_preset", 2'd1, 32'd0);
        chk_reg("rst_count", 2'd2, 32'd0);
        chk_reg("rst_rsvd", 2'd3, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("sel_hit", {31'd0, sel}, 32'd1);
        addr = 32'h0000_7F10;
        #1;
        check("miss_sel", {31'd0, sel}, 32'd0);
        check("miss_rdata", rdata, 32'd0);
        addr = 32'h0000_7F14; wdata = 32'h55; we = 1'b1;
        tick_n(1);
        we = 1'b0;
        chk_reg("miss_wr_ignored", 2'd1, 32'd0);
        wr(2'd2, 32'd123);
        chk_reg("count_wr_ignored", 2'd2, 32'd0);
`ifndef TIMER_PRESCALE_EN
        wr(2'd3, 32'hFFFF);
        chk_reg("rsvd_wr_ignored", 2'd3, 32'd0);
`endif

        // One-shot countdown from 5
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        tick_n(1);
        chk_reg("os_load_cycle", 2'd2, 32'd0);
        for (int i = 0; i <= 5; i++) begin
            tick_n(1);
            chk_reg($sformatf("os_count_%0d", i), 2'd2, 32'(5 - i));
        end
        check("os_irq_at_zero", {31'd0, irq}, 32'd0);
        tick_n(1);
        check("os_irq_rise", {31'd0, irq}, 32'd1);
        chk_reg("os_en_cleared", 2'd0, 32'h8);
        tick_n(3);
        check("os_irq_held", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'd0);
        check("os_irq_cleared", {31'd0, irq}, 32'd0);

        // Auto-reload, period 5
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        n = 0;
        do begin tick_n(1); n++; end while (!irq && n < 20);
        check("rl_first_irq_delay", 32'(n), 32'd6);
        tick_n(1);
        check("rl_irq_pulse", {31'd0, irq}, 32'd0);
        chk_reg("rl_reloaded", 2'd2, 32'd3);
        n = 1;
        do begin tick_n(1); n++; end while (!irq && n < 20);
        check("rl_period_1", 32'(n), 32'd5);
        for (int p = 2; p <= 3; p++) begin
            n = 0;
            do begin tick_n(1); n++; end while (!irq && n < 20);
            check($sformatf("rl_period_%0d", p), 32'(n), 32'd5);
        end
        wr(2'd0, 32'd0);
        tick_n(1);

        // Stop mid-count, then re-enable with irq masked
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        tick_n(5);
        chk_reg("stop_pre", 2'd2, 32'd7);
        wr(2'd0, 32'd0);
        chk_reg("stop_at_6", 2'd2, 32'd6);
        tick_n(3);
        chk_reg("stop_hold", 2'd2, 32'd6);
        check("stop_no_irq", {31'd0, irq}, 32'd0);
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        tick_n(2);
        chk_reg("reen_reload", 2'd2, 32'd2);
        tick_n(3);
        chk_reg("masked_int_en_clr", 2'd0, 32'd0);
        check("masked_irq", {31'd0, irq}, 32'd0);
        wr(2'd0, 32'd0);

        // PRESET = 0: INT on first CNT cycle
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick_n(3);
        check("p0_irq_not_yet", {31'd0, irq}, 32'd0);
        tick_n(1);
        check("p0_irq", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'd0);

        // CTRL write landing while in INT: written EN and irq set both win
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        tick_n(3);
        wr(2'd0, 32'h9);
        chk_reg("int_wr_en_wins", 2'd0, 32'h9);
        check("int_wr_set_wins", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'd0);
        check("int_wr_clear", {31'd0, irq}, 32'd0);
        tick_n(2);

        // Reset mid-count
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h9);
        tick_n(3);
        chk_reg("mid_count", 2'd2, 32'd19);
        do_reset();
        chk_reg("mrst_ctrl", 2'd0, 32'd0);
        chk_reg("mrst_preset", 2'd1, 32'd0);
        chk_reg("mrst_count", 2'd2, 32'd0);
        check("mrst_irq", {31'd0, irq}, 32'd0);
        tick_n(3);
        chk_reg("mrst_idle", 2'd2, 32'd0);

`ifdef TIMER_PRESCALE_EN
        // Prescale 2: decrement every third CNT cycle
        wr(2'd3, 32'd2);
        chk_reg("ps_readback", 2'd3, 32'd2);
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        tick_n(2);
        chk_reg("ps_load", 2'd2, 32'd3);
        for (int k = 1; k <= 9; k++) begin
            tick_n(1);
            chk_reg($sformatf("ps_count_k%0d", k), 2'd2, 32'(3 - k / 3));
        end
        check("ps_irq_before", {31'd0, irq}, 32'd0);
        tick_n(1);
        check("ps_irq", {31'd0, irq}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
